// File: rtl/uart_cmd_sequencer_pkg.sv
// uart_cmd_sequencer_pkg: shared types and constants for the UART command sequencer.
// Contents: FSM state enum, command opcodes, error codes, default frame sync byte.
package uart_cmd_pkg;
    typedef enum logic [2:0] {
        IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, TX
    } state_t;
    localparam logic [7:0] OP_WRITE      = 8'h01;
    localparam logic [7:0] OP_READ       = 8'h02;
    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM  = 2'd1;
    localparam logic [1:0] ERR_OPCODE    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if: byte-in, register-bus and response-out signals of the sequencer.
// slave  = sequencer side: takes rx_data/rx_valid, reg_rdata, tx_ready;
//          drives reg_addr/reg_wdata/reg_wr_en/reg_rd_en, tx_data/tx_valid, busy, err/err_code.
// master = environment side (receiver, register bank, transmitter), directions mirrored.
interface uart_cmd_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err;
    logic [1:0] err_code;
    modport slave (
        input  rx_data, rx_valid, reg_rdata, tx_ready,
        output reg_addr, reg_wdata, reg_wr_en, reg_rd_en, tx_data, tx_valid, busy, err, err_code
    );
    modport master (
        output rx_data, rx_valid, reg_rdata, tx_ready,
        input  reg_addr, reg_wdata, reg_wr_en, reg_rd_en, tx_data, tx_valid, busy, err, err_code
    );
endinterface

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: inter-byte gap counter with synchronous clear, count enable and saturation.
// Ports: clk, rst_n (async active-low), clr (zero the count), en (count this cycle),
//        expired (count has reached TIMEOUT_CYCLES-1 while enabled).
module uart_gap_timer #(
    parameter int TIMEOUT_CYCLES = 86800
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAX = '1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != MAX) cnt <= cnt + 1'b1;
    end
    assign expired = en && cnt >= LIMIT;
endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: assembles SYNC/CMD/ADDR/DATA/CHK frames and drives register strobes and read responses.
// Ports: clk, rst_n (async active-low), bus (slave modport): received bytes in, register
//        write/read strobes with address/data out, read data in, response byte out over
//        valid/ready, busy, one-cycle err pulse with sticky err_code.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 86800,
    parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_cmd_sequencer_if.slave bus
);
    state_t     state;
    logic [7:0] cmd;
    logic       expired;
    logic       in_frame;
    logic       chk_bad;
    logic       op_bad;
    assign in_frame = state inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK};
    assign chk_bad  = bus.rx_data != (cmd ^ bus.reg_addr ^ bus.reg_wdata);
    assign op_bad   = cmd != OP_WRITE && cmd != OP_READ;
    // Holding the counter at zero in IDLE covers the clear on entry to GET_CMD.
    uart_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.rx_valid || state == IDLE),
        .en      (in_frame),
        .expired (expired)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cmd           <= '0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_wr_en <= 1'b0;
            bus.reg_rd_en <= 1'b0;
            bus.tx_data   <= '0;
            bus.tx_valid  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
            bus.err_code  <= ERR_NONE;
        end else begin
            bus.err       <= 1'b0;
            bus.reg_wr_en <= 1'b0;
            bus.reg_rd_en <= 1'b0;
            case (state)
                IDLE: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                    state    <= GET_CMD;
                    bus.busy <= 1'b1;
                end
                GET_CMD, GET_ADDR, GET_DATA, GET_CHK: begin
                    // A byte arriving in the same cycle as expiry takes priority.
                    if (bus.rx_valid) begin
                        case (state)
                            GET_CMD: begin
                                cmd   <= bus.rx_data;
                                state <= GET_ADDR;
                            end
                            GET_ADDR: begin
                                bus.reg_addr <= bus.rx_data;
                                state        <= GET_DATA;
                            end
                            GET_DATA: begin
                                bus.reg_wdata <= bus.rx_data;
                                state         <= GET_CHK;
                            end
                            default: if (chk_bad || op_bad) begin
                                bus.err      <= 1'b1;
                                bus.err_code <= chk_bad ? ERR_CHECKSUM : ERR_OPCODE;
                                bus.busy     <= 1'b0;
                                state        <= IDLE;
                            end else begin
                                bus.reg_wr_en <= cmd == OP_WRITE;
                                bus.reg_rd_en <= cmd == OP_READ;
                                state         <= EXEC;
                            end
                        endcase
                    end else if (expired) begin
                        bus.err      <= 1'b1;
                        bus.err_code <= ERR_TIMEOUT;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                EXEC: begin
                    state    <= cmd == OP_READ ? RD_WAIT : IDLE;
                    bus.busy <= cmd == OP_READ;
                end
                RD_WAIT: begin
                    bus.tx_data  <= bus.reg_rdata;
                    bus.tx_valid <= 1'b1;
                    state        <= TX;
                end
                TX: if (bus.tx_ready) begin
                    bus.tx_valid <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Frame-level controller that sits behind the UART byte receiver and sequences what happens to each received byte. It assembles 5-byte command frames, checks them, and issues single-cycle register write/read strobes to a register bank. Read results are handed to a UART transmitter through a valid/ready handshake. It also enforces an inter-byte timeout and reports frame errors.

## Interface
- `TIMEOUT_CYCLES`, default 86800: maximum clk cycles between consecutive bytes of one frame (about 10 byte times at 868 clk/bit).
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  single-cycle pulse per received byte (receiver ack).
- `reg_addr`  out  8  register address, held from ADDR byte until next frame.
- `reg_wdata`  out  8  write data, held from DATA byte until next frame.
- `reg_wr_en`  out  1  one-cycle write strobe.
- `reg_rd_en`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid the cycle after `reg_rd_en`.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  response valid; held until accepted.
- `tx_ready`  in  1  transmitter can accept.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  last error: 0 none, 1 checksum, 2 bad opcode, 3 timeout; holds until next `err`.

## Operation
- Frame layout: SYNC, CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA.
- Opcodes:
  - 8'h01 WRITE: DATA is written to ADDR.
  - 8'h02 READ: DATA is ignored, but still covered by CHK.
- States: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, TX.
- IDLE:
  - `rx_valid` with `rx_data`==SYNC_BYTE -> GET_CMD.
  - Any other byte is silently discarded.
- GET_CMD / GET_ADDR / GET_DATA / GET_CHK: each `rx_valid` latches the byte and advances one state.
- GET_CHK on `rx_valid`:
  - Checksum mismatch -> err, code 1, IDLE.
  - Otherwise, opcode not 01/02 -> err, code 2, IDLE.
  - Otherwise -> EXEC.
- EXEC:
  - WRITE: `reg_wr_en`=1 for this cycle only, then IDLE.
  - READ: `reg_rd_en`=1 for this cycle only, then RD_WAIT.
- RD_WAIT: capture `reg_rdata` into `tx_data`, set `tx_valid`, go to TX.
- TX: hold `tx_valid` and `tx_data` stable until `tx_valid`&&`tx_ready`. In that cycle, clear `tx_valid` on the next edge and go to IDLE.
- Timeout:
  - The gap counter clears on every `rx_valid` and on entry to GET_CMD.
  - It counts in GET_CMD..GET_CHK only.
  - Reaching TIMEOUT_CYCLES-1 -> err, code 3, IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- `rx_valid` in EXEC/RD_WAIT/TX is dropped; the SYNC search restarts in IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - All outputs 0: `reg_addr`, `reg_wdata`, `tx_data`, strobes, `tx_valid`, `busy`, `err`, `err_code`.
- Write latency: `reg_wr_en` is high in the cycle after the CHK byte's `rx_valid`.
- Read latency:
  - `reg_rd_en` is high in the cycle after the CHK byte's `rx_valid`.
  - `tx_valid` rises 2 cycles after `reg_rd_en`.
- `err` is high in the cycle after the offending `rx_valid` or the timeout hit.
- Simultaneous `rx_valid` and timeout in the same cycle: the byte wins and the counter clears.
- `reg_wr_en` and `reg_rd_en` are never high together.
- Reset asserted mid-frame or in TX: everything is cleared immediately. An outstanding `tx_valid` drops without handshake.

## Structure
- Shared package `uart_cmd_pkg`:
  - state enum;
  - opcode constants OP_WRITE/OP_READ;
  - error-code constants;
  - default SYNC_BYTE.
- One sub-module, `uart_gap_timer`: the clear/enable/saturating counter with a `expired` output, parameterised by TIMEOUT_CYCLES.

## Test plan
- Write: A5 01 10 3C 2D -> one-cycle `reg_wr_en` with `reg_addr`=0x10, `reg_wdata`=0x3C; no `err`.
- Read with backpressure:
  - Stimulus: A5 02 07 00 05, `reg_rdata`=0x5A, `tx_ready` low for 3 cycles.
  - Response: `tx_valid`=1 with `tx_data`=0x5A held stable, one transfer, then `busy`=0.
- Bad checksum: A5 01 10 3C 00 -> `err` pulse, `err_code`=1, no strobe.
- Bad opcode:
  - A5 07 00 00 07 -> `err_code`=2.
  - Then noise bytes 00 FF -> ignored, no `err`.
- Timeout:
  - TIMEOUT_CYCLES=20, send A5 01, then silence -> `err_code`=3 exactly 20 cycles after the last byte.
  - A byte arriving exactly on cycle 19 -> no error.
- Reset mid-frame:
  - Stimulus: `rst_n` low after A5 01 10, then a full valid write frame.
  - Response: all outputs 0 during reset; the new frame writes correctly.
